// File: rtl/bg_pkg.sv
// Shared constants and types for the background RAM writer.
// Geometry of the 160x120 1-bit background, RGB444 field layout and FSM states.
package bg_pkg;

    localparam int unsigned H_PIX     = 160;
    localparam int unsigned V_PIX     = 120;
    localparam int unsigned FRAME_PIX = H_PIX * V_PIX;
    localparam int unsigned ADDR_W    = 15;
    localparam int unsigned THRESH    = 23;

    // RGB444 nibble positions within a 12-bit colour word {R, G, B}
    localparam int unsigned NIB_W = 4;
    localparam int unsigned R_LSB = 8;
    localparam int unsigned G_LSB = 4;
    localparam int unsigned B_LSB = 0;

    typedef enum logic [1:0] {
        IDLE,
        CAPTURE,
        FLUSH,
        DONE
    } state_t;

endpackage

// File: rtl/bg_ram_writer_pix_addr_thresh.sv
// Per-pixel datapath: linear address by shift-add, 1-bit colour threshold,
// and the registered RAM write port (one cycle from transfer to write).
module pix_addr_thresh
    import bg_pkg::*;
#(
    parameter int unsigned ADDR_W = bg_pkg::ADDR_W,
    parameter int unsigned THRESH = bg_pkg::THRESH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              wr_en,
    input  logic [7:0]        x,
    input  logic [7:0]        y,
    input  logic [11:0]       color,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_data,
    output logic              ram_wren
);

    logic [ADDR_W-1:0] addr_c;
    logic [5:0]        sum_c;
    logic              data_c;

    // y*160 + x as (y<<7) + (y<<5) + x, and R+G+B compared against the threshold
    always_comb begin
        addr_c = ADDR_W'({y, 7'b0}) + ADDR_W'({y, 5'b0}) + ADDR_W'(x);
        sum_c  = 6'(color[R_LSB +: NIB_W]) + 6'(color[G_LSB +: NIB_W])
               + 6'(color[B_LSB +: NIB_W]);
        data_c = (sum_c >= 6'(THRESH));
    end

    // Write port register; address and data hold while no write is pending
    always_ff @(posedge clk) begin
        if (!resetn) begin
            ram_address <= '0;
            ram_data    <= 1'b0;
            ram_wren    <= 1'b0;
        end else begin
            ram_wren <= wr_en;
            if (wr_en) begin
                ram_address <= addr_c;
                ram_data    <= data_c;
            end
        end
    end

endmodule

// File: rtl/bg_ram_writer.sv
// Background RAM writer: captures one thresholded 160x120 frame per start pulse.
// Optional raster-order checking is enabled by defining BG_RAM_WRITER_RASTER_CHECK_EN.
module bg_ram_writer
    import bg_pkg::*;
#(
    parameter int unsigned H_PIX  = bg_pkg::H_PIX,
    parameter int unsigned V_PIX  = bg_pkg::V_PIX,
    parameter int unsigned ADDR_W = bg_pkg::ADDR_W,
    parameter int unsigned THRESH = bg_pkg::THRESH
) (
    input  logic              clk,
    input  logic              resetn,
    input  logic              start,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [7:0]        in_x,
    input  logic [7:0]        in_y,
    input  logic [11:0]       in_color,
    output logic [ADDR_W-1:0] ram_address,
    output logic              ram_data,
    output logic              ram_wren,
    output logic              busy,
    output logic              done,
    output logic              err
);

    localparam int unsigned FRAME_N = H_PIX * V_PIX;

    state_t      state, state_nx;
    logic [14:0] pix_cnt;
    logic        xfer, in_range, wr_en, last_pix, start_ok, order_err;

    assign start_ok = (state == IDLE) && start;
    assign xfer     = in_valid && in_ready;
    assign in_range = (in_x < 8'(H_PIX)) && (in_y < 8'(V_PIX));
    assign wr_en    = xfer && in_range;
    assign last_pix = (pix_cnt == 15'(FRAME_N - 1));

    // State register
    always_ff @(posedge clk) begin
        if (!resetn) state <= IDLE;
        else         state <= state_nx;
    end

    // Next-state and handshake/status outputs
    always_comb begin
        state_nx = state;
        in_ready = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            IDLE:    if (start) state_nx = CAPTURE;
            CAPTURE: begin
                in_ready = 1'b1;
                busy     = 1'b1;
                if (wr_en && last_pix) state_nx = FLUSH;
            end
            FLUSH: begin
                busy     = 1'b1;
                state_nx = DONE;
            end
            DONE: begin
                done     = 1'b1;
                state_nx = IDLE;
            end
            default: state_nx = IDLE;
        endcase
    end

`ifdef BG_RAM_WRITER_RASTER_CHECK_EN
    logic [7:0] ex, ey;

    assign order_err = (in_x != ex) || (in_y != ey);

    // Expected raster position follows the last received pixel, not the expected one
    always_ff @(posedge clk) begin
        if (!resetn || start_ok) begin
            ex <= '0;
            ey <= '0;
        end else if (wr_en) begin
            if (in_x == 8'(H_PIX - 1)) begin
                ex <= '0;
                ey <= in_y + 8'd1;
            end else begin
                ex <= in_x + 8'd1;
                ey <= in_y;
            end
        end
    end
`else
    assign order_err = 1'b0;
`endif

    // Pixel counter and sticky error flag, both cleared by start
    always_ff @(posedge clk) begin
        if (!resetn || start_ok) begin
            pix_cnt <= '0;
            err     <= 1'b0;
        end else begin
            if (wr_en) pix_cnt <= pix_cnt + 15'd1;
            if ((xfer && !in_range) || (wr_en && order_err)) err <= 1'b1;
        end
    end

    pix_addr_thresh #(
        .ADDR_W (ADDR_W),
        .THRESH (THRESH)
    ) u_pix (
        .clk         (clk),
        .resetn      (resetn),
        .wr_en       (wr_en),
        .x           (in_x),
        .y           (in_y),
        .color       (in_color),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren)
    );

endmodule

// File: tb/tb_bg_ram_writer.sv
// Self-checking bench for bg_ram_writer against an arithmetic reference model.
module tb_bg_ram_writer;

    logic        clk = 1'b0;
    logic        resetn, start, in_valid;
    logic [7:0]  in_x, in_y;
    logic [11:0] in_color;
    logic        in_ready, ram_data, ram_wren, busy, done, err;
    logic [14:0] ram_address;

    int n_checks = 0;
    int n_fail   = 0;

    // reference model state: expected sticky error and expected raster position
    bit m_err;
    int ex, ey;

    always #5 clk = ~clk;

    bg_ram_writer dut (
        .clk         (clk),
        .resetn      (resetn),
        .start       (start),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_x        (in_x),
        .in_y        (in_y),
        .in_color    (in_color),
        .ram_address (ram_address),
        .ram_data    (ram_data),
        .ram_wren    (ram_wren),
        .busy        (busy),
        .done        (done),
        .err         (err)
    );

    function automatic int ref_addr(input int x, input int y);
        return y * 160 + x;
    endfunction

    function automatic logic ref_bit(input logic [11:0] c);
        return (int'(c[11:8]) + int'(c[7:4]) + int'(c[3:0])) >= 23;
    endfunction

    function automatic void model_start();
        m_err = 1'b0;
        ex = 0;
        ey = 0;
    endfunction

    function automatic void model_xfer(input int x, input int y);
        if (x >= 160 || y >= 120) m_err = 1'b1;
        else begin
`ifdef BG_RAM_WRITER_RASTER_CHECK_EN
            if (x != ex || y != ey) m_err = 1'b1;
            if (x == 159) begin ex = 0; ey = y + 1; end
            else begin ex = x + 1; ey = y; end
`endif
        end
    endfunction

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        resetn = 1'b0; start = 1'b0; in_valid = 1'b0;
        tick();
        resetn = 1'b1;
        m_err = 1'b0;
    endtask

    task automatic do_start();
        start = 1'b1; in_valid = 1'b0;
        tick();
        start = 1'b0;
        model_start();
    endtask

    task automatic push(input int x, input int y, input logic [11:0] c);
        in_valid = 1'b1; in_x = 8'(x); in_y = 8'(y); in_color = c;
        tick();
        in_valid = 1'b0;
        model_xfer(x, y);
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL rst_wren: got %b want 0", ram_wren); end
        n_checks++; if (ram_address !== 15'd0) begin n_fail++; $display("FAIL rst_addr: got %0d want 0", ram_address); end
        n_checks++; if (ram_data !== 1'b0) begin n_fail++; $display("FAIL rst_data: got %b want 0", ram_data); end
        n_checks++; if ({in_ready, busy, done, err} !== 4'b0) begin n_fail++; $display("FAIL rst_status: got %b want 0000", {in_ready, busy, done, err}); end
        // mid-capture reset after an error and 10 pixels
        do_start();
        push(160, 0, 12'hFFF);
        for (int i = 0; i < 10; i++) push(i, 0, 12'($urandom));
        resetn = 1'b0; in_valid = 1'b1; in_x = 8'd10; in_y = 8'd0;
        tick();
        m_err = 1'b0;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL midrst_wren: got %b want 0", ram_wren); end
        n_checks++; if ({in_ready, busy, err} !== 3'b0) begin n_fail++; $display("FAIL midrst_status: got %b want 000", {in_ready, busy, err}); end
        resetn = 1'b1;
        tick();
        in_valid = 1'b0;
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL postrst_wren: got %b want 0", ram_wren); end
    endtask

    task automatic test_single();
        logic [11:0] cols[4] = '{12'hFFF, 12'h777, 12'h887, 12'h877};
        int x, y;
        logic [11:0] c;
        // start with a simultaneous pixel: pixel is not accepted
        start = 1'b1; in_valid = 1'b1; in_x = 8'd1; in_y = 8'd1; in_color = 12'hFFF;
        tick();
        start = 1'b0; in_valid = 1'b0;
        model_start();
        n_checks++; if (ram_wren !== 1'b0) begin n_fail++; $display("FAIL start_xfer_wren: got %b want 0", ram_wren); end
        n_checks++; if ({busy, in_ready} !== 2'b11) begin n_fail++; $display("FAIL start_busy: got %b want 11", {busy, in_ready}); end
        for (int i = 0; i < 4; i++) begin
            push(5, 2, cols[i]);
            n_checks++; if (ram_wren !== 1'b1) begin n_fail++; $display("FAIL single_wren[%0d]: got %b want 1", i, ram_wren); end
            n_checks++; if (ram_address !== 15'd325) begin n_fail++; $display("FAIL single_addr[%0d]: got %0d want 325", i, ram_address); end
            n_checks++; if (ram_data !== ref_bit(cols[i])) begin n_fail++; $display("FAIL single_data[%0d]: got %b want %b", i, ram_data, ref_bit(cols[i])); end
            n_checks++; if (err !== m_err) begin n_fail++; $display("FAIL single_err[%0d]: got %b want %b", i, err, m_err); end
            tick();
            n_checks++; if (ram_wren !== 1'b0 || ram_address !== 15'd325 || ram_data !== ref_bit(cols[i])) begin
                n_fail++; $display("FAIL single_hold[%0d]: got wren=%b addr=%0d data=%b", i, ram_wren, ram_address, ram_data); end
        end
        for (int i = 0; i < 16; i++) begin
            x = $urandom_range(0, 159); y = $urandom_range(0, 119); c = 12'($urandom);
            push(x, y, c);
            n_checks++; if (ram_wren !== 1'b1 || int'(ram_address) != ref_addr(x, y) || ram_data !== ref_bit(c)) begin
                n_fail++; $display("FAIL rand_pix[%0d]: got wren=%b addr=%0d data=%b want 1 %0d %b", i, ram_wren, ram_address, ram_data, ref_addr(x, y), ref_bit(c)); end
        end
        // start during capture is ignored
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if ({busy, in_ready, err} !== {2'b11, m_err}) begin n_fail++; $display("FAIL start_ignored: got %b want %b", {busy, in_ready, err}, {2'b11, m_err}); end
        do_reset();
    endtask

`ifdef BG_RAM_WRITER_RASTER_CHECK_EN
    task automatic test_raster();
        do_start();
        push(0, 0, 12'hFFF);
        n_checks++; if (err !== 1'b0 || ram_wren !== 1'b1 || ram_address !== 15'd0) begin n_fail++; $display("FAIL raster_first: got err=%b wren=%b addr=%0d", err, ram_wren, ram_address); end
        push(2, 0, 12'h000);
        n_checks++; if (err !== 1'b1 || ram_wren !== 1'b1 || ram_address !== 15'd2) begin n_fail++; $display("FAIL raster_skip: got err=%b wren=%b addr=%0d", err, ram_wren, ram_address); end
        n_checks++; if (ex != 3 || ey != 0) begin n_fail++; $display("FAIL raster_model_next: got (%0d,%0d) want (3,0)", ex, ey); end
        start = 1'b1;
        tick();
        start = 1'b0;
        n_checks++; if (busy !== 1'b1 || err !== 1'b1) begin n_fail++; $display("FAIL raster_start_ignored: got busy=%b err=%b want 1 1", busy, err); end
        do_reset();
    endtask
`endif

    // streams a whole raster frame, returns observed wren count and datapath mismatches
    task automatic stream_frame(input bit gaps, output int wren_cnt, output int mism);
        int x, y;
        logic [11:0] c;
        wren_cnt = 0; mism = 0;
        for (int idx = 0; idx < 19200; idx++) begin
            x = idx % 160; y = idx / 160;
            if (gaps && $urandom_range(0, 7) == 0) begin
                in_valid = 1'b0;
                tick();
                if (ram_wren) begin wren_cnt++; mism++; end
            end
            if (in_ready !== 1'b1) mism++;
            c = 12'($urandom);
            push(x, y, c);
            if (ram_wren) wren_cnt++;
            if (ram_wren !== 1'b1 || int'(ram_address) != ref_addr(x, y) || ram_data !== ref_bit(c)) mism++;
        end
    endtask

    task automatic test_full_frame();
        int wc, mm;
        do_start();
        stream_frame(1'b1, wc, mm);
        n_checks++; if (wc != 19200) begin n_fail++; $display("FAIL frame_wren_count: got %0d want 19200", wc); end
        n_checks++; if (mm != 0) begin n_fail++; $display("FAIL frame_datapath: got %0d mismatches want 0", mm); end
        n_checks++; if (ram_address !== 15'd19199) begin n_fail++; $display("FAIL frame_last_addr: got %0d want 19199", ram_address); end
        n_checks++; if ({in_ready, busy, done} !== 3'b010) begin n_fail++; $display("FAIL frame_flush: got %b want 010", {in_ready, busy, done}); end
        tick();
        n_checks++; if ({done, busy, ram_wren, err} !== {3'b100, m_err}) begin n_fail++; $display("FAIL frame_done: got %b want %b", {done, busy, ram_wren, err}, {3'b100, m_err}); end
        tick();
        n_checks++; if ({done, in_ready} !== 2'b00) begin n_fail++; $display("FAIL frame_idle: got %b want 00", {done, in_ready}); end
    endtask

    task automatic test_out_of_range();
        int wc, mm;
        do_start();
        push(160, 0, 12'hFFF);
        n_checks++; if (ram_wren !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL oor_x: got wren=%b err=%b want 0 1", ram_wren, err); end
        push(0, 120, 12'hFFF);
        n_checks++; if (ram_wren !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL oor_y: got wren=%b err=%b want 0 1", ram_wren, err); end
        push($urandom_range(160, 255), $urandom_range(0, 255), 12'($urandom));
        n_checks++; if (ram_wren !== 1'b0 || in_ready !== 1'b1) begin n_fail++; $display("FAIL oor_rand: got wren=%b ready=%b want 0 1", ram_wren, in_ready); end
        stream_frame(1'b0, wc, mm);
        n_checks++; if (wc != 19200 || mm != 0) begin n_fail++; $display("FAIL oor_frame: got %0d writes %0d mismatches want 19200 0", wc, mm); end
        n_checks++; if (in_ready !== 1'b0 || err !== 1'b1) begin n_fail++; $display("FAIL oor_end: got ready=%b err=%b want 0 1", in_ready, err); end
        tick();
        n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL oor_done: got %b want 1", done); end
        tick();
        do_start();
        n_checks++; if (err !== 1'b0 || busy !== 1'b1) begin n_fail++; $display("FAIL oor_restart: got err=%b busy=%b want 0 1", err, busy); end
    endtask

    initial begin
        resetn = 1'b0; start = 1'b0; in_valid = 1'b0;
        in_x = '0; in_y = '0; in_color = '0;
        model_start();
        test_reset();
        test_single();
`ifdef BG_RAM_WRITER_RASTER_CHECK_EN
        test_raster();
`endif
        test_full_frame();
        test_out_of_range();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
